// File: rtl/miriscv_prefetch_unit.sv
// miriscv instruction prefetch unit: credit-limited req/gnt/rvalid fetch
// into a small {pc, instr} queue, with stale-response discard on redirect.
module miriscv_prefetch_unit #(
  parameter int XLEN            = 32,
  parameter int FIFO_DEPTH      = 4,
  parameter int MAX_OUTSTANDING = 2
) (
  input  logic            clk_i,
  input  logic            arstn_i,
  input  logic [XLEN-1:0] boot_addr_i,
  output logic            instr_req_o,
  output logic [XLEN-1:0] instr_addr_o,
  input  logic            instr_gnt_i,
  input  logic            instr_rvalid_i,
  input  logic [XLEN-1:0] instr_rdata_i,
  input  logic [XLEN-1:0] cu_pc_bra_i,
  input  logic            cu_stall_f_i,
  input  logic            cu_kill_f_i,
  input  logic            cu_boot_addr_load_en_i,
  output logic [XLEN-1:0] fetched_pc_addr_o,
  output logic [XLEN-1:0] fetched_pc_next_addr_o,
  output logic [31:0]     instr_o,
  output logic            fetch_rvalid_o
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int AW =
    (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  localparam logic [CW:0]   DEPTH_C = (CW + 1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] MAXO_C  = CW'(MAX_OUTSTANDING);
  localparam logic [AW-1:0] ALAST   = AW'(MAX_OUTSTANDING - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [XLEN-1:0] req_pc_q, req_pc_d;
  logic [CW-1:0]   out_cnt_q, out_cnt_d;
  logic [CW-1:0]   disc_cnt_q, disc_cnt_d;
  logic [CW-1:0]   fifo_cnt_q, fifo_cnt_d;
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [AW-1:0]   aq_wr_q, aq_rd_q;

  logic [XLEN-1:0] pc_mem_q  [FIFO_DEPTH];
  logic [31:0]     ins_mem_q [FIFO_DEPTH];
  logic [XLEN-1:0] aq_mem_q  [MAX_OUTSTANDING];

  logic            redir;
  logic [XLEN-1:0] tgt;
  logic [CW:0]     credit_sum;
  logic            grant;
  logic            drop;
  logic            push;
  logic            pop;

  assign redir = cu_boot_addr_load_en_i | cu_kill_f_i;
  assign tgt   = cu_boot_addr_load_en_i ? boot_addr_i : cu_pc_bra_i;

  assign credit_sum = {1'b0, out_cnt_q} + {1'b0, fifo_cnt_q};

  assign instr_req_o = arstn_i & ~redir
                     & (out_cnt_q < MAXO_C)
                     & (credit_sum < DEPTH_C);
  assign instr_addr_o = req_pc_q;

  assign grant = instr_req_o & instr_gnt_i;
  assign drop  = (disc_cnt_q != '0) | redir;
  assign push  = instr_rvalid_i & ~drop;

  assign fetch_rvalid_o = (fifo_cnt_q != '0)
                        & ~cu_stall_f_i & ~redir;
  assign pop = fetch_rvalid_o;

  assign fetched_pc_addr_o      = pc_mem_q[rd_ptr_q];
  assign fetched_pc_next_addr_o = pc_mem_q[rd_ptr_q] + XLEN'(4);
  assign instr_o                = ins_mem_q[rd_ptr_q];

  always_comb begin
    req_pc_d   = req_pc_q;
    out_cnt_d  = out_cnt_q;
    disc_cnt_d = disc_cnt_q;
    fifo_cnt_d = fifo_cnt_q;
    // grant is already masked by redirect, so out_cnt needs no special case
    if (grant)          out_cnt_d = out_cnt_d + ONE;
    if (instr_rvalid_i) out_cnt_d = out_cnt_d - ONE;
    if (redir) begin
      req_pc_d   = tgt;
      disc_cnt_d = out_cnt_d;
      fifo_cnt_d = '0;
    end else begin
      if (grant) req_pc_d = req_pc_q + XLEN'(4);
      if (instr_rvalid_i && disc_cnt_q != '0)
        disc_cnt_d = disc_cnt_q - ONE;
      if (push) fifo_cnt_d = fifo_cnt_d + ONE;
      if (pop)  fifo_cnt_d = fifo_cnt_d - ONE;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      req_pc_q   <= '0;
      out_cnt_q  <= '0;
      disc_cnt_q <= '0;
      fifo_cnt_q <= '0;
    end else begin
      req_pc_q   <= req_pc_d;
      out_cnt_q  <= out_cnt_d;
      disc_cnt_q <= disc_cnt_d;
      fifo_cnt_q <= fifo_cnt_d;
    end
  end

  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        pc_mem_q[i]  <= '0;
        ins_mem_q[i] <= '0;
      end
    end else if (redir) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (push) begin
        pc_mem_q[wr_ptr_q]  <= aq_mem_q[aq_rd_q];
        ins_mem_q[wr_ptr_q] <= instr_rdata_i;
        wr_ptr_q            <= wr_ptr_q + PW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PW'(1);
    end
  end

  // Issued-address queue: one entry per outstanding request, stale or not
  always_ff @(posedge clk_i or negedge arstn_i) begin
    if (!arstn_i) begin
      aq_wr_q <= '0;
      aq_rd_q <= '0;
      for (int i = 0; i < MAX_OUTSTANDING; i++)
        aq_mem_q[i] <= '0;
    end else begin
      if (grant) begin
        aq_mem_q[aq_wr_q] <= req_pc_q;
        aq_wr_q <= (aq_wr_q == ALAST) ? '0 : aq_wr_q + AW'(1);
      end
      if (instr_rvalid_i)
        aq_rd_q <= (aq_rd_q == ALAST) ? '0 : aq_rd_q + AW'(1);
    end
  end

endmodule
